muldiv_hilo: RTL

Parametrised iterative multiply/divide unit with integrated HI/LO architectural registers for the MIPS datapath. Replaces the single-cycle HI/LO store. Executes MULT/MULTU/DIV/DIVU over WIDTH+1 cycles with a busy/done handshake to the control unit, and retains MTHI/MTLO writes and HI/LO reads. Sits beside the ALU; operands come from busA/busB, and the read port feeds the register-file writeback mux.

---
 rtl/muldiv_pkg.sv | 9 +
 rtl/muldiv_core.sv | 88 ++++++++
 rtl/muldiv_hilo.sv | 89 ++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Operation and FSM encodings shared by the multiply/divide core and the HI/LO wrapper.
package muldiv_pkg;
    localparam logic [1:0] OP_MULT  = 2'd0;
    localparam logic [1:0] OP_MULTU = 2'd1;
    localparam logic [1:0] OP_DIV   = 2'd2;
    localparam logic [1:0] OP_DIVU  = 2'd3;

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;
endpackage

// File: rtl/muldiv_core.sv
// Iterative datapath: radix-2 shift-add multiply and restoring divide on operand magnitudes,
// with the sign applied combinationally to the finished result.
module muldiv_core
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_last,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic             res_valid
);
    localparam int CW = $clog2(WIDTH);

    // r_rem is the product high half (multiply) or remainder (divide); r_q is the low half / quotient.
    logic [WIDTH-1:0]   r_rem, r_q, r_b;
    logic [CW-1:0]      r_cnt;
    logic               r_div, r_neg_q, r_neg_r, r_dz;

    logic               w_is_mul, w_signed, w_sa, w_sb, w_dge;
    logic [WIDTH-1:0]   w_ma, w_mb, w_dsub, w_quo, w_rmd;
    logic [WIDTH:0]     w_madd, w_dsh;
    logic [2*WIDTH-1:0] w_prod, w_sprod;

    assign w_is_mul = (i_op == OP_MULT) || (i_op == OP_MULTU);
    assign w_signed = (i_op == OP_MULT) || (i_op == OP_DIV);
    assign w_sa     = w_signed && i_a[WIDTH-1];
    assign w_sb     = w_signed && i_b[WIDTH-1];
    assign w_ma     = w_sa ? -i_a : i_a;
    assign w_mb     = w_sb ? -i_b : i_b;

    assign w_madd = r_q[0] ? ({1'b0, r_rem} + {1'b0, r_b}) : {1'b0, r_rem};
    assign w_dsh  = {r_rem, r_q[WIDTH-1]};
    assign w_dge  = (w_dsh >= {1'b0, r_b});
    // The difference is below the divisor whenever it is kept, so the low WIDTH bits suffice.
    assign w_dsub = w_dsh[WIDTH-1:0] - r_b;

    assign o_last = (r_cnt == CW'(WIDTH-1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rem     <= '0;
            r_q       <= '0;
            r_b       <= '0;
            r_cnt     <= '0;
            r_div     <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_dz      <= 1'b0;
            res_valid <= 1'b0;
        end else if (i_load) begin
            r_rem     <= '0;
            r_q       <= w_ma;
            r_b       <= w_mb;
            r_cnt     <= '0;
            r_div     <= !w_is_mul;
            r_neg_q   <= w_sa ^ w_sb;
            r_neg_r   <= w_sa && !w_is_mul;
            r_dz      <= (i_b == '0);
            res_valid <= 1'b0;
        end else if (i_step) begin
            if (r_div) begin
                r_rem <= w_dge ? w_dsub : w_dsh[WIDTH-1:0];
                r_q   <= {r_q[WIDTH-2:0], w_dge};
            end else begin
                r_rem <= w_madd[WIDTH:1];
                r_q   <= {w_madd[0], r_q[WIDTH-1:1]};
            end
            r_cnt <= r_cnt + 1'b1;
            if (o_last) res_valid <= 1'b1;
        end
    end

    // Divide by zero leaves the dividend magnitude as remainder, so only the quotient needs overriding.
    assign w_prod  = {r_rem, r_q};
    assign w_sprod = r_neg_q ? -w_prod : w_prod;
    assign w_quo   = r_dz ? '1 : (r_neg_q ? -r_q : r_q);
    assign w_rmd   = r_neg_r ? -r_rem : r_rem;
    assign res_hi  = r_div ? w_rmd : w_sprod[2*WIDTH-1:WIDTH];
    assign res_lo  = r_div ? w_quo : w_sprod[WIDTH-1:0];
endmodule

// File: rtl/muldiv_hilo.sv
// HI/LO architectural registers with MTHI/MTLO writes, a read mux, and the FSM
// sequencing the iterative multiply/divide core.
module muldiv_hilo
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd_sel,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] hi_data,
    output logic [WIDTH-1:0] lo_data,
    output logic             busy,
    output logic             done
);
    state_t           r_state;
    logic [WIDTH-1:0] r_hi, r_lo;
    logic             r_busy, r_done;

    logic             w_load, w_step, w_last, w_res_valid;
    logic [WIDTH-1:0] w_res_hi, w_res_lo;

    assign w_load = (r_state == IDLE) && start;
    assign w_step = (r_state == CALC);

    muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clk       (clk),
        .resetn    (resetn),
        .i_load    (w_load),
        .i_step    (w_step),
        .i_op      (op),
        .i_a       (a),
        .i_b       (b),
        .o_last    (w_last),
        .res_hi    (w_res_hi),
        .res_lo    (w_res_lo),
        .res_valid (w_res_valid)
    );

    // MTHI/MTLO are only honoured in IDLE, so a coincident start still lets its result win later.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (wr_hi) r_hi <= wdata;
                    if (wr_lo) r_lo <= wdata;
                    if (start) begin
                        r_state <= CALC;
                        r_busy  <= 1'b1;
                    end
                end
                CALC: begin
                    if (w_last) r_state <= FIX;
                end
                FIX: begin
                    if (w_res_valid) begin
                        r_hi <= w_res_hi;
                        r_lo <= w_res_lo;
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rd_data = rd_sel ? r_hi : r_lo;
    assign hi_data = r_hi;
    assign lo_data = r_lo;
    assign busy    = r_busy;
    assign done    = r_done;
endmodule
